// File: rtl/mult_arb_pkg.sv
// ---------------------------------------------------------------------------
// mult_arb_pkg : shared constants and helpers for the multiplier arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_IN_W    = 32;
    localparam int DEF_CONST_W = 16;

    function automatic int id_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Coefficients are Q1.(CONST_W-1), so the product is rescaled by CONST_W-1 bits
    function automatic int frac(input int const_w);
        return const_w - 1;
    endfunction

    localparam int FRAC = frac(DEF_CONST_W);

endpackage

`default_nettype wire

// File: rtl/lut_multiplier.sv
// ---------------------------------------------------------------------------
// lut_multiplier : combinational signed fixed-point constant multiply
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lut_multiplier
    import mult_arb_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int CONST_W = 16
) (
    input  logic signed [IN_W-1:0]    a,
    input  logic signed [CONST_W-1:0] b,
    output logic signed [IN_W-1:0]    result
);

    localparam int FRAC_W = frac(CONST_W);

    logic signed [IN_W+CONST_W-1:0] prod;

    assign prod = a * b;

    // Arithmetic shift floors toward minus infinity; no rounding, no saturation
    assign result = IN_W'(prod >>> FRAC_W);

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin grant starting the search at ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_vld
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!grant_vld && req[idx]) begin
                grant_vld      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = ID_W'(idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter : N requesters share one multiplier via 2-stage pipe
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int IN_W    = DEF_IN_W,
    parameter int CONST_W = DEF_CONST_W,
    parameter int ID_W    = id_w(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*IN_W-1:0]      req_a,
    input  logic [N_REQ*CONST_W-1:0]   req_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ID_W-1:0]            out_id,
    output logic [IN_W-1:0]            out_data,
    output logic                       busy
);

    typedef struct packed {
        logic signed [IN_W-1:0]    a;
        logic signed [CONST_W-1:0] b;
        logic [ID_W-1:0]           id;
        logic                      vld;
    } s1_t;

    typedef struct packed {
        logic signed [IN_W-1:0] data;
        logic [ID_W-1:0]        id;
        logic                   vld;
    } s2_t;

    s1_t                    s1;
    s2_t                    s2;
    logic [ID_W-1:0]        ptr;
    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        grant_idx;
    logic                   grant_vld;
    logic                   s2_adv;
    logic                   s1_load_ok;
    logic                   accept;
    logic signed [IN_W-1:0] mul_out;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    lut_multiplier #(
        .IN_W    (IN_W),
        .CONST_W (CONST_W)
    ) u_mul (
        .a      (s1.a),
        .b      (s1.b),
        .result (mul_out)
    );

    // S1 may load when empty or when it drains into S2 this cycle
    assign s2_adv     = !s2.vld || out_ready;
    assign s1_load_ok = rst_n && (!s1.vld || s2_adv);
    assign accept     = grant_vld && s1_load_ok;
    assign req_ready  = s1_load_ok ? grant : '0;

    assign out_valid = s2.vld;
    assign out_id    = s2.id;
    assign out_data  = s2.data;
    assign busy      = s1.vld | s2.vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= '0;
            s2  <= '0;
            ptr <= '0;
        end else begin
            if (s2_adv) begin
                s2.vld <= s1.vld;
                if (s1.vld) begin
                    s2.data <= mul_out;
                    s2.id   <= s1.id;
                end
            end
            if (s1_load_ok) begin
                s1.vld <= accept;
                if (accept) begin
                    s1.a  <= req_a[grant_idx*IN_W +: IN_W];
                    s1.b  <= req_b[grant_idx*CONST_W +: CONST_W];
                    s1.id <= grant_idx;
                end
            end
            if (accept) begin
                ptr <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_share_arbiter : randomized self-checking bench with reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mult_share_arbiter;

    localparam int NR  = 4;
    localparam int IW  = 32;
    localparam int CW  = 16;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*IW-1:0]  req_a;
    logic [NR*CW-1:0]  req_b;
    logic              out_valid;
    logic              out_ready;
    logic [IDW-1:0]    out_id;
    logic [IW-1:0]     out_data;
    logic              busy;

    always #5 clk = ~clk;

    mult_share_arbiter #(
        .N_REQ   (NR),
        .IN_W    (IW),
        .CONST_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .busy      (busy)
    );

    typedef struct {
        logic [IW-1:0] a;
        logic [CW-1:0] b;
    } op_t;

    typedef struct {
        int            id;
        logic [IW-1:0] data;
        bit            at_out;
    } res_t;

    op_t           pend[NR][$];   // per-requester operand streams, head is presented
    res_t          mq[$];         // results in flight, oldest first
    int            ptr_m;
    logic [NR-1:0] mask;
    int            total;
    int            bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // floor((a*b) / 2^(CW-1)), low IW bits
    function automatic logic [IW-1:0] ref_mul(input logic [IW-1:0] a, input logic [CW-1:0] b);
        longint p;
        longint q;
        longint d;
        d = longint'(1) << (CW - 1);
        p = longint'($signed(a)) * longint'($signed(b));
        q = p / d;
        if (p < 0 && (p % d) != 0) q = q - 1;
        return q[IW-1:0];
    endfunction

    function automatic bit pending_any();
        for (int r = 0; r < NR; r++)
            if (pend[r].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_op(input int r, input logic [IW-1:0] a, input logic [CW-1:0] b);
        op_t o;
        o.a = a;
        o.b = b;
        pend[r].push_back(o);
    endtask

    task automatic apply();
        for (int r = 0; r < NR; r++) begin
            req_valid[r] = (pend[r].size() > 0) && mask[r];
            if (pend[r].size() > 0) begin
                req_a[r*IW +: IW] = pend[r][0].a;
                req_b[r*CW +: CW] = pend[r][0].b;
            end
        end
    endtask

    task automatic step();
        int            win;
        bit            s2f;
        bit            s1f;
        bit            can;
        bit            hs;
        logic [NR-1:0] er;
        res_t          t;
        @(negedge clk);
        s2f = (mq.size() > 0) && mq[0].at_out;
        s1f = (mq.size() > 0) && !mq[mq.size()-1].at_out;
        can = rst_n && !(s1f && s2f && !out_ready);
        win = -1;
        for (int i = 0; i < NR; i++) begin
            int j;
            j = (ptr_m + i) % NR;
            if (win < 0 && req_valid[j]) win = j;
        end
        hs = can && (win >= 0);
        er = '0;
        if (hs) er[win] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(s2f));
        chk("busy", 64'(busy), 64'(mq.size() > 0));
        if (s2f) begin
            chk("out_id", 64'(out_id), 64'(mq[0].id));
            chk("out_data", 64'(out_data), 64'(mq[0].data));
        end
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            ptr_m = 0;
        end else begin
            if (s2f && out_ready) void'(mq.pop_front());
            if (mq.size() > 0 && !mq[0].at_out) begin
                t = mq[0];
                t.at_out = 1'b1;
                mq[0] = t;
            end
            if (hs) begin
                t.id     = win;
                t.data   = ref_mul(pend[win][0].a, pend[win][0].b);
                t.at_out = 1'b0;
                mq.push_back(t);
                void'(pend[win].pop_front());
                ptr_m = (win + 1) % NR;
            end
        end
        #1;
        apply();
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((pending_any() || mq.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (pending_any() || mq.size() > 0) chk("drain_timeout", 64'(n), 64'(budget + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        total     = 0;
        bad       = 0;
        ptr_m     = 0;
        mask      = '1;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_id", 64'(out_id), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        apply();

        // single requester, 100 * 0.5
        push_op(0, 32'd100, 16'd16384);
        apply();
        run_until_idle(20);
        step();

        // signed and truncation cases back to back on req1
        push_op(1, 32'hFFFF_FFFD, 16'd16384);
        push_op(1, 32'd1000, 16'h8000);
        push_op(1, 32'hFFFF_FFFF, 16'd1);
        push_op(1, 32'h7FFF_FFFF, 16'd32767);
        apply();
        run_until_idle(30);

        // fairness with all requesters valid
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < NR; r++)
                push_op(r, $urandom, 16'($urandom));
        apply();
        run_until_idle(60);

        // pointer: req2 alone, then req1 and req3 together
        push_op(2, 32'd7, 16'd1234);
        apply();
        step();
        push_op(1, 32'd11, 16'd2000);
        push_op(3, 32'd13, 16'd3000);
        apply();
        run_until_idle(30);

        // backpressure
        out_ready = 1'b0;
        push_op(0, 32'd21, 16'd500);
        push_op(1, 32'd22, 16'd600);
        push_op(2, 32'd23, 16'd700);
        apply();
        repeat (7) step();
        out_ready = 1'b1;
        run_until_idle(30);

        // reset with both stages full
        out_ready = 1'b0;
        for (int r = 0; r < NR; r++) push_op(r, $urandom, 16'($urandom));
        apply();
        repeat (3) step();
        rst_n = 1'b0;
        for (int r = 0; r < NR; r++) pend[r].delete();
        apply();
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        push_op(1, 32'hFFFF_FF00, 16'h4000);
        apply();
        run_until_idle(20);

        // randomized traffic with valid drops, backpressure and occasional reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int r;
                r = $urandom_range(0, NR - 1);
                if (pend[r].size() < 3) begin
                    case ($urandom_range(0, 3))
                        0:       push_op(r, 32'h8000_0000, 16'h8000);
                        1:       push_op(r, 32'h7FFF_FFFF, 16'h7FFF);
                        default: push_op(r, $urandom, 16'($urandom));
                    endcase
                end
            end
            mask      = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 299) != 0);
            apply();
            step();
        end
        rst_n     = 1'b1;
        mask      = '1;
        out_ready = 1'b1;
        apply();
        run_until_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
